comm_responder: RTL and testbench
=================================

# comm_responder

Host-command responder for the logic-analyzer core: the DUT-side end of the host link. It deserializes 8N1 UART bytes arriving on `RX`, pairs them into a 16-bit command for the command processor, and serializes one-byte responses back out on `TX`. It sits between the board UART pins and the LA command/dump logic, at the main 100 MHz `clk`.

## Interface
- `BAUD_DIV`, 868, clocks per bit (115200 baud at 100 MHz); legal range 16..4095
- `TMO_BITS`, 20, bit-times allowed between end of byte 1 and start of byte 2 before byte 1 is discarded
- `clk`  in  1  system clock; the single clock of the block
- `rst`  in  1  reset, synchronous, active-high
- `RX`  in  1  serial input from host, asynchronous, idle high
- `TX`  out  1  serial output to host, idle high
- `cmd`  out  16  assembled command; byte 1 in [15:8], byte 2 in [7:0]
- `cmd_rdy`  out  1  level; new `cmd` valid
- `clr_cmd_rdy`  in  1  one-cycle clear of `cmd_rdy`
- `resp`  in  8  response byte to transmit
- `send_resp`  in  1  one-cycle request to transmit `resp`
- `resp_sent`  out  1  level; last response fully shifted out
- `tx_busy`  out  1  frame in progress on `TX`
- `frm_err`  out  1  one-cycle pulse; stop bit sampled low

## Operation
- Reset values: `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0, `tx_busy`=0, `frm_err`=0; RX synchronizer flops=1; byte-pair state = expecting byte 1.
- RX path: `RX` through a 2-flop synchronizer; all decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronized falling edge; bit counter loaded with BAUD_DIV/2 (integer floor).
  - START: at count expiry, if line high -> IDLE (glitch rejected, no error); else reload BAUD_DIV -> DATA.
  - DATA: 8 samples at bit centers, LSB first, shifted into an 8-bit register -> STOP.
  - STOP: sample at center; high = valid byte, low = `frm_err` pulse, byte discarded, byte-pair state reset to expecting byte 1. Return to IDLE in both cases.
- Byte pairing: valid byte 1 stored in a staging register (not `cmd`); valid byte 2 loads `cmd` = {stage, byte} and sets `cmd_rdy`. `cmd` changes only on that load.
- Timeout: a counter runs while expecting byte 2 and RX FSM is IDLE; after TMO_BITS*BAUD_DIV clocks byte 1 is discarded, state returns to expecting byte 1. No flag.
- `cmd_rdy` clears on `clr_cmd_rdy` or on detection of the start bit of the next byte 1. Set and clear in the same cycle: set wins.
- TX FSM states: IDLE, SHIFT. `send_resp` in IDLE loads a 10-bit frame {1, resp, 0}, clears `resp_sent`, sets `tx_busy`. Frame shifts LSB first, one bit per BAUD_DIV clocks. After the stop-bit period: `tx_busy`=0, `resp_sent`=1, -> IDLE.
- `send_resp` while `tx_busy` is ignored; the current frame is unaffected.
- RX and TX are fully independent; full-duplex traffic is legal.
- `rst` mid-frame aborts both paths immediately to reset values. `TX` returns high on the next edge.

## Timing
- TX: `send_resp` high at edge N -> `TX` low from N+1; each bit lasts exactly BAUD_DIV clocks; `tx_busy` falls and `resp_sent` rises at N+1+10*BAUD_DIV.
- RX: falling edge on `RX` pin -> detected 2–3 clocks later (synchronizer). Samples at detect + BAUD_DIV/2 + k*BAUD_DIV, k=0 (start) .. 9 (stop).
- `cmd`/`cmd_rdy` update on the clock after the byte-2 stop sample. `frm_err` pulses on the clock after a bad stop sample.
- Tolerance: correct reception with host bit period within ±3% of BAUD_DIV.

## Test plan
- BAUD_DIV=16: host sends 0x81 then 0x23 -> `cmd`=16'h8123, `cmd_rdy`=1 one clock after byte-2 stop sample; `clr_cmd_rdy` -> `cmd_rdy`=0, `cmd` held.
- Pulse `send_resp` with `resp`=0xA5 -> `TX` pattern 0,1,0,1,0,0,1,0,1,1, 16 clocks per bit. `resp_sent` rises 161 clocks after request. A second `send_resp` at clock 40 is ignored.
- Byte 1 = 0x02, then 1 bit-time later byte 2 = 0x5A. Repeat with 25 bit-times of idle between bytes (TMO_BITS=20) -> second case yields no `cmd_rdy`; a following pair 0x04,0x00 gives `cmd`=16'h0400.
- Stop bit forced low on byte 2 -> one-cycle `frm_err`, `cmd_rdy` stays 0, `cmd` unchanged. Next clean pair 0x11,0x22 -> `cmd`=16'h1122.
- 4-clock low glitch on `RX` -> no `frm_err`, no byte, FSM back in IDLE. Separately, `clr_cmd_rdy` coincident with `cmd_rdy` set -> `cmd_rdy`=1.
- Full duplex: host sends 0xC0,0x00 while DUT transmits 0x3C -> both complete correctly. `rst` asserted mid-TX frame -> `TX`=1 and `tx_busy`=0 next clock.

Source files
------------

// File: rtl/comm_responder.sv
// comm_responder: host-link UART endpoint. Receives 8N1 bytes on RX, pairs them
// into a 16-bit command, and serializes one-byte responses out on TX.
module comm_responder #(
    parameter int unsigned BAUD_DIV = 868,
    parameter int unsigned TMO_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frm_err
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    // Start-bit wait; the detect cycle itself supplies the extra clock.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
    localparam int unsigned TMO_CLKS = TMO_BITS * BAUD_DIV;
    localparam int unsigned TMO_W = $clog2(TMO_CLKS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CLKS - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {TxIdle, TxShift} tx_state_e;

    // ------------------------------------------------------------------ RX path
    logic             rx_sync1_q, rx_sync2_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             pair_q, pair_d;    // 1: byte 1 staged, waiting for byte 2
    logic [7:0]       stage_q, stage_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             frm_err_q, frm_err_d;
    logic             rx_fall, rx_tick;

    assign rx_fall = rx_prev_q & ~rx_sync2_q;
    assign rx_tick = (rx_cnt_q == '0);

    // RX synchronizer, FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            pair_q     <= 1'b0;
            stage_q    <= '0;
            tmo_q      <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            rx_sync1_q <= RX;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            pair_q     <= pair_d;
            stage_q    <= stage_d;
            tmo_q      <= tmo_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // RX next-state: start detect, glitch rejection, 8 data bits, stop bit
    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RxIdle:  if (rx_fall) rx_state_d = RxStart;
            RxStart: if (rx_tick) rx_state_d = rx_sync2_q ? RxIdle : RxData;
            RxData:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = RxStop;
            RxStop:  if (rx_tick) rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX datapath: bit timing, shifting, byte pairing, timeout, cmd handshake
    always_comb begin
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        pair_d     = pair_q;
        stage_d    = stage_q;
        tmo_d      = '0;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        frm_err_d  = 1'b0;

        // Clear first so that a set in the same cycle overrides it
        if (clr_cmd_rdy || (rx_state_q == RxIdle && rx_fall && !pair_q)) begin
            cmd_rdy_d = 1'b0;
        end

        // Staged byte 1 is dropped if byte 2 does not start in time
        if (pair_q && rx_state_q == RxIdle) begin
            if (tmo_q == TMO_LAST) begin
                pair_d = 1'b0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        unique case (rx_state_q)
            RxIdle: begin
                if (rx_fall) rx_cnt_d = HALF_M1;
            end
            RxStart: begin
                if (rx_tick) begin
                    rx_cnt_d = FULL_M1;
                    rx_bit_d = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            RxData: begin
                if (rx_tick) begin
                    rx_cnt_d   = FULL_M1;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            RxStop: begin
                if (rx_tick) begin
                    if (!rx_sync2_q) begin
                        frm_err_d = 1'b1;
                        pair_d    = 1'b0;
                    end else if (!pair_q) begin
                        stage_d = rx_shift_q;
                        pair_d  = 1'b1;
                    end else begin
                        cmd_d     = {stage_q, rx_shift_q};
                        cmd_rdy_d = 1'b1;
                        pair_d    = 1'b0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end
            end
            default: rx_cnt_d = '0;
        endcase
    end

    // ------------------------------------------------------------------ TX path
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [9:0]       tx_shift_q, tx_shift_d;  // bit 0 drives the line; idles all-ones
    logic             resp_sent_q, resp_sent_d;
    logic             tx_tick;

    assign tx_tick = (tx_cnt_q == '0);

    // TX FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    // TX next-state: accept a request only when idle, finish after the stop bit
    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TxIdle:  if (send_resp) tx_state_d = TxShift;
            TxShift: if (tx_tick && tx_bit_q == 4'd9) tx_state_d = TxIdle;
            default: tx_state_d = TxIdle;
        endcase
    end

    // TX datapath: frame load, per-bit timing and shift-out
    always_comb begin
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        resp_sent_d = resp_sent_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (send_resp) begin
                    tx_shift_d  = {1'b1, resp, 1'b0};
                    tx_cnt_d    = FULL_M1;
                    tx_bit_d    = '0;
                    resp_sent_d = 1'b0;
                end
            end
            TxShift: begin
                if (tx_tick) begin
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    tx_cnt_d   = FULL_M1;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'd9) resp_sent_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end
            end
            default: tx_cnt_d = '0;
        endcase
    end

    assign TX        = tx_shift_q[0];
    assign tx_busy   = (tx_state_q == TxShift);
    assign resp_sent = resp_sent_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_comm_responder.sv
// Bench for comm_responder at BAUD_DIV=16, TMO_BITS=20: directed host traffic,
// response frames, timeout, framing error, glitch, duplex and mid-frame reset.
module tb_comm_responder;

    localparam int unsigned BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX, cmd_rdy, resp_sent, tx_busy, frm_err;
    logic [15:0] cmd;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_q[$];
    logic        rdy_prev = 1'b0;

    comm_responder #(.BAUD_DIV(BD), .TMO_BITS(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every new cmd_rdy must match the oldest expected command
    always @(negedge clk) begin
        if (!rst && cmd_rdy && !rdy_prev) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_cmd", 32'(cmd), 32'(exp_q.pop_front()));
        end
        rdy_prev <= cmd_rdy;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        idle(BD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            idle(BD);
        end
        RX = stop;
        idle(BD);
        RX = 1'b1;
    endtask

    // Byte 2 stop sample lands 154.5 clocks after its start edge; cmd_rdy follows
    task automatic send_pair(input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back({b1, b2});
        send_byte(b1, 1'b1);
        idle(BD);
        fork
            send_byte(b2, 1'b1);
            begin
                idle(154);
                check("rdy_early", 32'(cmd_rdy), 32'd0);
                idle(1);
                check("rdy_set", 32'(cmd_rdy), 32'd1);
                check("cmd_val", 32'(cmd), 32'({b1, b2}));
            end
        join
    endtask

    // Drives one response request and checks the frame bit by bit
    task automatic tx_frame(input logic [7:0] r, input logic poke40);
        logic [9:0] fr;
        fr = {1'b1, r, 1'b0};
        resp = r;
        send_resp = 1'b1;
        for (int c = 1; c <= 161; c++) begin
            idle(1);
            if (c == 1) send_resp = 1'b0;
            if (poke40 && c == 40) begin
                resp = ~r;
                send_resp = 1'b1;
            end
            if (poke40 && c == 41) send_resp = 1'b0;
            if (c == 1) check("tx_start_low", 32'(TX), 32'd0);
            if (c == 2) check("tx_busy_on", 32'(tx_busy), 32'd1);
            if (c == 2) check("resp_sent_clr", 32'(resp_sent), 32'd0);
            if (c >= 9 && c <= 153 && (c - 9) % 16 == 0) begin
                check("tx_bit", 32'(TX), 32'(fr[(c - 9) / 16]));
            end
            if (c == 160) begin
                check("busy_before_end", 32'(tx_busy), 32'd1);
                check("sent_before_end", 32'(resp_sent), 32'd0);
            end
            if (c == 161) begin
                check("busy_end", 32'(tx_busy), 32'd0);
                check("sent_end", 32'(resp_sent), 32'd1);
                check("tx_idle_end", 32'(TX), 32'd1);
            end
        end
    endtask

    initial begin
        logic seen;

        // Reset state
        idle(3);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_resp_sent", 32'(resp_sent), 32'd0);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_frm_err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        idle(4);

        // Basic pair and clear
        send_pair(8'h81, 8'h23);
        idle(4);
        clr_cmd_rdy = 1'b1;
        idle(1);
        clr_cmd_rdy = 1'b0;
        idle(1);
        check("clr_rdy", 32'(cmd_rdy), 32'd0);
        check("clr_cmd_held", 32'(cmd), 32'h8123);

        // Response frame with an ignored second request mid-frame
        tx_frame(8'hA5, 1'b1);
        idle(30);
        check("no_second_frame_busy", 32'(tx_busy), 32'd0);
        check("no_second_frame_tx", 32'(TX), 32'd1);

        // Timeout: short gap pairs, long gap discards byte 1
        send_pair(8'h02, 8'h5A);
        send_byte(8'h02, 1'b1);
        idle(25 * BD);
        send_byte(8'h5A, 1'b1);
        idle(2 * BD);
        check("tmo_no_rdy", 32'(cmd_rdy), 32'd0);
        check("tmo_cmd_held", 32'(cmd), 32'h025A);
        idle(25 * BD);
        send_pair(8'h04, 8'h00);

        // Framing error on byte 2
        send_byte(8'h33, 1'b1);
        idle(BD);
        fork
            send_byte(8'h44, 1'b0);
            begin
                idle(154);
                check("fe_before", 32'(frm_err), 32'd0);
                idle(1);
                check("fe_pulse", 32'(frm_err), 32'd1);
                idle(1);
                check("fe_after", 32'(frm_err), 32'd0);
            end
        join
        idle(BD);
        check("fe_no_rdy", 32'(cmd_rdy), 32'd0);
        check("fe_cmd_held", 32'(cmd), 32'h0400);
        send_pair(8'h11, 8'h22);

        // Short low glitch is rejected without error and without a byte
        idle(BD);
        RX = 1'b0;
        idle(4);
        RX = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            idle(1);
            if (frm_err) seen = 1'b1;
        end
        check("glitch_no_fe", 32'(seen), 32'd0);
        send_pair(8'h55, 8'h66);

        // clr_cmd_rdy held across the set cycle: set wins
        exp_q.push_back(16'h7788);
        send_byte(8'h77, 1'b1);
        idle(BD);
        fork
            send_byte(8'h88, 1'b1);
            begin
                idle(100);
                clr_cmd_rdy = 1'b1;
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    idle(1);
                    if (cmd_rdy) seen = 1'b1;
                end
                clr_cmd_rdy = 1'b0;
                check("set_wins_seen", 32'(seen), 32'd1);
                idle(3);
                check("set_wins_held", 32'(cmd_rdy), 32'd1);
            end
        join
        idle(BD);

        // Full duplex
        fork
            tx_frame(8'h3C, 1'b0);
            send_pair(8'hC0, 8'h00);
        join
        idle(BD);

        // Reset in the middle of a TX frame
        resp = 8'h3C;
        send_resp = 1'b1;
        idle(1);
        send_resp = 1'b0;
        idle(50);
        check("pre_rst_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        idle(1);
        check("mid_rst_tx", 32'(TX), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_cmd", 32'(cmd), 32'd0);
        check("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
        check("mid_rst_sent", 32'(resp_sent), 32'd0);
        rst = 1'b0;
        idle(4);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
